// File: rtl/xpb_lut_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : xpb_lut_ram_if
// Brief    : Load-stream and lookup-lane bundle for the XPB lookup table.
// Revision : 1.0
// ============================================================================
interface xpb_lut_ram_if #(
    parameter int IDX_BITS = 5,
    parameter int DATA_W   = 1024,
    parameter int WORD_W   = 32,
    parameter int NUM_CH   = 2
);
    logic                       load_start;
    logic                       load_valid;
    logic [WORD_W-1:0]          load_data;
    logic                       load_ready;
    logic                       table_ready;
    logic                       lk_valid;
    logic [NUM_CH*IDX_BITS-1:0] lk_idx;
    logic                       lk_out_valid;
    logic                       lk_miss;
    logic [NUM_CH*DATA_W-1:0]   lk_data;

    modport master (
        output load_start, load_valid, load_data, lk_valid, lk_idx,
        input  load_ready, table_ready, lk_out_valid, lk_miss, lk_data
    );

    modport slave (
        input  load_start, load_valid, load_data, lk_valid, lk_idx,
        output load_ready, table_ready, lk_out_valid, lk_miss, lk_data
    );
endinterface
`default_nettype wire

// File: rtl/xpb_lut_ram.sv
`default_nettype none
// ============================================================================
// Module   : xpb_lut_ram
// Brief    : Streamed-in XPB constant table served to NUM_CH lookup lanes
//            with a fixed two-cycle registered latency.
// Revision : 1.0
// ============================================================================
module xpb_lut_ram #(
    parameter int IDX_BITS = 5,
    parameter int DATA_W   = 1024,
    parameter int WORD_W   = 32,
    parameter int NUM_CH   = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    xpb_lut_ram_if.slave       bus
);
    localparam int c_DEPTH = 2 ** IDX_BITS;
    localparam int c_WPE   = DATA_W / WORD_W;
    localparam int c_WCW   = $clog2(c_WPE);
    localparam logic [c_WCW-1:0]    c_WLAST = c_WCW'(c_WPE - 1);
    // Entry counter is zero-based over entries 1..DEPTH-1, so the last entry is DEPTH-2.
    localparam logic [IDX_BITS-1:0] c_ELAST = IDX_BITS'(c_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_load_ready;
    logic                       r_table_ready;
    logic [c_WCW-1:0]           r_word_cnt;
    logic [IDX_BITS-1:0]        r_ent_cnt;
    logic [DATA_W-1:0]          r_asm;
    logic [DATA_W-1:0]          r_mem [c_DEPTH];

    logic                       r_lk_v1;
    logic                       r_hit1;
    logic [NUM_CH*IDX_BITS-1:0] r_idx1;
    logic                       r_out_valid;
    logic                       r_miss;
    logic [NUM_CH*DATA_W-1:0]   r_lk_data;

    logic                       w_accept;
    logic                       w_word_last;
    logic                       w_wr_en;
    logic [IDX_BITS-1:0]        w_wr_addr;
    logic [DATA_W-1:0]          w_entry;
    logic [DATA_W-1:0]          w_rd [NUM_CH];

    // A coincident load_start wins over a load word.
    assign w_accept    = bus.load_valid && (r_state == S_LOAD) && !bus.load_start;
    assign w_word_last = (r_word_cnt == c_WLAST);
    assign w_wr_en     = w_accept && w_word_last && !reset;
    assign w_wr_addr   = r_ent_cnt + IDX_BITS'(1);
    assign w_entry     = {bus.load_data, r_asm[DATA_W-1:WORD_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_load_ready  <= 1'b0;
            r_table_ready <= 1'b0;
            r_word_cnt    <= '0;
            r_ent_cnt     <= '0;
        end else if (bus.load_start) begin
            r_state       <= S_LOAD;
            r_load_ready  <= 1'b1;
            r_table_ready <= 1'b0;
            r_word_cnt    <= '0;
            r_ent_cnt     <= '0;
        end else if (w_accept) begin
            if (w_word_last) begin
                r_word_cnt <= '0;
                if (r_ent_cnt == c_ELAST) begin
                    r_state       <= S_READY;
                    r_load_ready  <= 1'b0;
                    r_table_ready <= 1'b1;
                    r_ent_cnt     <= '0;
                end else begin
                    r_ent_cnt <= r_ent_cnt + IDX_BITS'(1);
                end
            end else begin
                r_word_cnt <= r_word_cnt + c_WCW'(1);
            end
        end
    end

    // Storage and assembly register are data-only and deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_asm <= w_entry;
        end
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_entry;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_rd[c] = '0;
            if (r_hit1 && (r_idx1[c*IDX_BITS +: IDX_BITS] != '0)) begin
                w_rd[c] = r_mem[r_idx1[c*IDX_BITS +: IDX_BITS]];
            end
        end
    end

    // Hit/miss is decided by table_ready at acceptance, not at the storage read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lk_v1     <= 1'b0;
            r_hit1      <= 1'b0;
            r_idx1      <= '0;
            r_out_valid <= 1'b0;
            r_miss      <= 1'b0;
            r_lk_data   <= '0;
        end else begin
            r_lk_v1     <= bus.lk_valid;
            r_hit1      <= r_table_ready;
            r_idx1      <= bus.lk_idx;
            r_out_valid <= r_lk_v1;
            r_miss      <= r_lk_v1 && !r_hit1;
            if (r_lk_v1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_lk_data[c*DATA_W +: DATA_W] <= w_rd[c];
                end
            end
        end
    end

    assign bus.load_ready   = r_load_ready;
    assign bus.table_ready  = r_table_ready;
    assign bus.lk_out_valid = r_out_valid;
    assign bus.lk_miss      = r_miss;
    assign bus.lk_data      = r_lk_data;
endmodule
`default_nettype wire

// File: doc/xpb_lut_ram.md
# xpb_lut_ram

Programmable, multi-channel lookup table of precomputed reduction constants (XPB values) for the modular squaring datapath. It replaces per-modulus hard-coded ROM tables: entries are streamed in once per modulus over a narrow word interface, then served to `NUM_CH` independent index lanes with a fixed two-cycle registered latency. The block sits between the host/config loader and the squaring circuit's reduction adder tree.

## Interface
- `IDX_BITS`, 5: index width per lane; table depth is `2**IDX_BITS`.
- `DATA_W`, 1024: entry width.
- `WORD_W`, 32: load word width; `DATA_W % WORD_W == 0` and `DATA_W/WORD_W >= 2`.
- `NUM_CH`, 2: number of parallel lookup lanes.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `load_start`  in  1  one-cycle pulse; begins a (re)load.
- `load_valid`  in  1  load word valid.
- `load_data`  in  WORD_W  load word.
- `load_ready`  out  1  block accepts a word this cycle.
- `table_ready`  out  1  table fully loaded; lookups are served.
- `lk_valid`  in  1  lookup request, all lanes together.
- `lk_idx`  in  NUM_CH*IDX_BITS  lane c index at `[c*IDX_BITS +: IDX_BITS]`.
- `lk_out_valid`  out  1  result valid.
- `lk_miss`  out  1  qualifies `lk_out_valid`: request arrived while `table_ready=0`.
- `lk_data`  out  NUM_CH*DATA_W  lane c entry at `[c*DATA_W +: DATA_W]`.

## Operation
- Entry 0 is hard-wired to zero and is never stored. Entries 1..`2**IDX_BITS-1` are loaded.
- There are three states:
  - IDLE: after reset. `load_ready=0`, `table_ready=0`.
  - LOAD: entered on `load_start`. `load_ready=1`.
  - READY: `table_ready=1`, `load_ready=0`.
- Load order: entry 1 first, ascending. Within an entry the least-significant word comes first. There are `WPE = DATA_W/WORD_W` words per entry.
- A word is accepted when `load_valid && load_ready`. Accepted words shift into an assembly register, and the word counter increments. On the WPE-th word, the assembled entry is written to storage at the entry counter, the word counter wraps to 0, and the entry counter increments.
- After the write of the last entry (`2**IDX_BITS-1`), the state moves to READY. `table_ready` rises the next cycle.
- `load_start` in any state clears both counters, drops `table_ready` the next cycle, and enters LOAD. This includes a restart during LOAD. Stored entries are not cleared. Each is overwritten only when its new value is fully assembled.
- `load_start` and `load_valid` in the same cycle: the start wins and the word is not accepted.
- Lookups are accepted every cycle; there is no backpressure.
  - If `table_ready=1` at acceptance, each lane returns its entry (zero for index 0).
  - Otherwise the result is all zeros with `lk_miss=1`.
- Lanes are independent. Identical indices on several lanes are legal.

## Timing
- Reset values: `load_ready=0`, `table_ready=0`, `lk_out_valid=0`, `lk_miss=0`, `lk_data=0`, counters=0, state=IDLE. Storage contents are not reset.
- Lookup latency is 2 cycles. `lk_idx` and `lk_valid` are registered in cycle T+1. Storage is read into the `lk_data` register in T+2, where `lk_out_valid` is asserted. Full throughput is one request per cycle.
- `lk_data` holds its last value when `lk_out_valid=0`.
- `table_ready` is sampled at request acceptance (cycle T). A request accepted in the cycle `load_start` is asserted still returns old data, not a miss. WPE>=2 guarantees storage is unchanged for 2 cycles after `load_start`.
- The last load word is accepted in cycle L. `table_ready=1` from L+1. A lookup in L+1 returns the new entries.
- Reset mid-load returns to IDLE and aborts the load. `table_ready` stays 0 until a complete reload.

## Test plan
- Default params. Reset, then `lk_valid` with idx {3,7} -> `lk_out_valid=1`, `lk_miss=1`, `lk_data=0`, 2 cycles later. `load_ready=0`.
- Load all 31 entries, 992 words, with word w of entry k = `{8'(k),8'(w),16'hA5A5}`. Then lookup {1,31} -> both lanes carry the pattern for k=1 and k=31 with word 0 at bits [31:0]. `table_ready` rises the cycle after word 992.
- `load_valid` toggled randomly -> counters advance only on accepted words, and the final table is identical to the gap-free load.
- Back-to-back lookups over every idx 0..31 on both lanes, one per cycle -> 32 consecutive valid results, latency 2. Index 0 gives 0.
- With the table loaded, pulse `load_start` together with a lookup of idx 5 -> old entry 5 returned, `lk_miss=0`. A lookup 2 cycles later -> `lk_miss=1`. Reload with the pattern XOR `32'hFFFFFFFF`, re-read idx 5 -> new value.
- `reset` asserted after 400 load words -> IDLE, `table_ready=0`. Restart with `load_start` mid-load -> counters restart at entry 1, word 0.
